// File: rtl/apb_multi_timer_if.sv
// APB3 slave bus bundle for apb_multi_timer.
// Master drives the request; the timer drives read data and response.
interface apb_multi_timer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:2]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_multi_timer.sv
// NUM_CH-channel APB3 down-counter timer with prescalers and maskable interrupts.
// Define TIMER_PWM_EN to add per-channel CMP registers and the PWM output port.
module apb_multi_timer #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int PRE_W      = 8,
    parameter int INTACTIVEH = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_multi_timer_if.slave  apb,
    output logic [NUM_CH-1:0] TIMINT,
    output logic              TIMINT_ANY
`ifdef TIMER_PWM_EN
    ,
    output logic [NUM_CH-1:0] PWM
`endif
);

    localparam logic [2:0] R_LOAD = 3'd0;
    localparam logic [2:0] R_VAL  = 3'd1;
    localparam logic [2:0] R_CTRL = 3'd2;
    localparam logic [2:0] R_PRE  = 3'd3;
    localparam logic [2:0] R_ICLR = 3'd4;
    localparam logic [2:0] R_RIS  = 3'd5;
    localparam logic [2:0] R_MIS  = 3'd6;
    localparam logic [2:0] R_CMP  = 3'd7;

    localparam logic [NUM_CH-1:0] INT_IDLE = (INTACTIVEH != 0) ? '0 : '1;
    localparam logic ANY_IDLE = (INTACTIVEH != 0) ? 1'b0 : 1'b1;

    logic [WIDTH-1:0]  load_q  [NUM_CH];
    logic [WIDTH-1:0]  load_d  [NUM_CH];
    logic [WIDTH-1:0]  value_q [NUM_CH];
    logic [WIDTH-1:0]  value_d [NUM_CH];
    logic [PRE_W-1:0]  pre_q   [NUM_CH];
    logic [PRE_W-1:0]  pre_d   [NUM_CH];
    logic [PRE_W-1:0]  pcnt_q  [NUM_CH];
    logic [PRE_W-1:0]  pcnt_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] inten_q, inten_d;
    logic [NUM_CH-1:0] oneshot_q, oneshot_d;
    logic [NUM_CH-1:0] ris_q, ris_d;
    logic [NUM_CH-1:0] timint_q, timint_d;
    logic              any_q, any_d;
`ifdef TIMER_PWM_EN
    logic [WIDTH-1:0]  cmp_q   [NUM_CH];
    logic [WIDTH-1:0]  cmp_d   [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
`endif

    logic [2:0]        ch_s;
    logic [2:0]        reg_s;
    logic              wr_s;
    logic [NUM_CH-1:0] hit_s;
    logic [NUM_CH-1:0] tick_s;
    logic [NUM_CH-1:0] mis_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    assign ch_s        = apb.PADDR[7:5];
    assign reg_s       = apb.PADDR[4:2];
    assign wr_s        = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign apb.PRDATA  = rdata_s;
    assign TIMINT      = timint_q;
    assign TIMINT_ANY  = any_q;
    assign unused_s    = ^apb.PWDATA;
`ifdef TIMER_PWM_EN
    assign PWM         = pwm_q;
`endif

    // A LOAD write on a tick edge swallows that tick entirely.
    always_comb begin
        hit_s  = '0;
        tick_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_s[i]  = wr_s && (ch_s == 3'(i));
            tick_s[i] = en_q[i] && (pcnt_q[i] == pre_q[i])
                        && !(hit_s[i] && (reg_s == R_LOAD));
        end
    end

    always_comb begin
        en_d      = en_q;
        inten_d   = inten_q;
        oneshot_d = oneshot_q;
        ris_d     = ris_q;
        for (int i = 0; i < NUM_CH; i++) begin
            load_d[i]  = load_q[i];
            value_d[i] = value_q[i];
            pre_d[i]   = pre_q[i];
            pcnt_d[i]  = en_q[i] ? pcnt_q[i] + PRE_W'(1) : '0;
`ifdef TIMER_PWM_EN
            cmp_d[i]   = cmp_q[i];
`endif
            if (tick_s[i]) begin
                pcnt_d[i] = '0;
                if (value_q[i] != '0) begin
                    value_d[i] = value_q[i] - WIDTH'(1);
                end else if (oneshot_q[i]) begin
                    en_d[i] = 1'b0;
                end else begin
                    value_d[i] = load_q[i];
                end
            end
            if (hit_s[i]) begin
                unique case (reg_s)
                    R_LOAD: begin
                        load_d[i]  = apb.PWDATA[WIDTH-1:0];
                        value_d[i] = apb.PWDATA[WIDTH-1:0];
                        pcnt_d[i]  = '0;
                    end
                    R_CTRL: begin
                        en_d[i]      = apb.PWDATA[0];
                        inten_d[i]   = apb.PWDATA[1];
                        oneshot_d[i] = apb.PWDATA[2];
                    end
                    R_PRE:  pre_d[i] = apb.PWDATA[PRE_W-1:0];
                    R_ICLR: ris_d[i] = 1'b0;
`ifdef TIMER_PWM_EN
                    R_CMP:  cmp_d[i] = apb.PWDATA[WIDTH-1:0];
`endif
                    default: ;
                endcase
            end
            // Expiry is applied after INTCLR so a coincident set wins.
            if (tick_s[i] && (value_q[i] == '0)) begin
                ris_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mis_s    = ris_q & inten_q;
        timint_d = (INTACTIVEH != 0) ? mis_s : ~mis_s;
        any_d    = (INTACTIVEH != 0) ? |mis_s : ~|mis_s;
`ifdef TIMER_PWM_EN
        pwm_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = en_q[i] && (value_q[i] < cmp_q[i]);
        end
`endif
    end

    always_comb begin
        rdata_s = '0;
        if (apb.PSEL) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_s == 3'(i)) begin
                    unique case (reg_s)
                        R_LOAD: rdata_s = 32'(load_q[i]);
                        R_VAL:  rdata_s = 32'(value_q[i]);
                        R_CTRL: rdata_s = {29'd0, oneshot_q[i],
                                           inten_q[i], en_q[i]};
                        R_PRE:  rdata_s = 32'(pre_q[i]);
                        R_RIS:  rdata_s = {31'd0, ris_q[i]};
                        R_MIS:  rdata_s = {31'd0, mis_s[i]};
`ifdef TIMER_PWM_EN
                        R_CMP:  rdata_s = 32'(cmp_q[i]);
`endif
                        default: rdata_s = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                load_q[i]  <= '0;
                value_q[i] <= '0;
                pre_q[i]   <= '0;
                pcnt_q[i]  <= '0;
`ifdef TIMER_PWM_EN
                cmp_q[i]   <= '0;
`endif
            end
            en_q      <= '0;
            inten_q   <= '0;
            oneshot_q <= '0;
            ris_q     <= '0;
            timint_q  <= INT_IDLE;
            any_q     <= ANY_IDLE;
`ifdef TIMER_PWM_EN
            pwm_q     <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                load_q[i]  <= load_d[i];
                value_q[i] <= value_d[i];
                pre_q[i]   <= pre_d[i];
                pcnt_q[i]  <= pcnt_d[i];
`ifdef TIMER_PWM_EN
                cmp_q[i]   <= cmp_d[i];
`endif
            end
            en_q      <= en_d;
            inten_q   <= inten_d;
            oneshot_q <= oneshot_d;
            ris_q     <= ris_d;
            timint_q  <= timint_d;
            any_q     <= any_d;
`ifdef TIMER_PWM_EN
            pwm_q     <= pwm_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_multi_timer.sv
// Scoreboard bench for apb_multi_timer: two instances (active-high and
// active-low interrupts) share one APB stimulus stream and one reference model.
module tb_apb_multi_timer;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int PW  = 8;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        psel   = 1'b0;
    logic        pen    = 1'b0;
    logic        pwr    = 1'b0;
    logic [7:2]  paddr  = '0;
    logic [31:0] pwdata = '0;

    logic [NCH-1:0] tim_h, tim_l;
    logic           any_h, any_l;
`ifdef TIMER_PWM_EN
    logic [NCH-1:0] pwm_h, pwm_l;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_multi_timer_if bh ();
    apb_multi_timer_if bl ();

    assign bh.PSEL = psel;   assign bl.PSEL = psel;
    assign bh.PENABLE = pen; assign bl.PENABLE = pen;
    assign bh.PWRITE = pwr;  assign bl.PWRITE = pwr;
    assign bh.PADDR = paddr; assign bl.PADDR = paddr;
    assign bh.PWDATA = pwdata;
    assign bl.PWDATA = pwdata;

    apb_multi_timer #(
        .NUM_CH(NCH), .WIDTH(W), .PRE_W(PW), .INTACTIVEH(1)
    ) dut_h (
        .PCLK(clk), .PRESETn(rstn), .apb(bh.slave),
        .TIMINT(tim_h), .TIMINT_ANY(any_h)
`ifdef TIMER_PWM_EN
        , .PWM(pwm_h)
`endif
    );

    apb_multi_timer #(
        .NUM_CH(NCH), .WIDTH(W), .PRE_W(PW), .INTACTIVEH(0)
    ) dut_l (
        .PCLK(clk), .PRESETn(rstn), .apb(bl.slave),
        .TIMINT(tim_l), .TIMINT_ANY(any_l)
`ifdef TIMER_PWM_EN
        , .PWM(pwm_l)
`endif
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endfunction

    // Reference model: channel state as the programmer sees it.
    logic [W-1:0]   m_load [NCH];
    logic [W-1:0]   m_val  [NCH];
    logic [W-1:0]   m_cmp  [NCH];
    logic [PW-1:0]  m_pre  [NCH];
    logic [PW-1:0]  m_pc   [NCH];
    logic [NCH-1:0] m_en, m_ie, m_os, m_ris, m_misr, m_pwmr;
    bit             mvalid = 1'b0;

    function automatic void model_step();
        int   c, r;
        logic wrs, lw, tick, expire;
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                m_load[i] = '0; m_val[i] = '0; m_cmp[i] = '0;
                m_pre[i]  = '0; m_pc[i]  = '0;
            end
            m_en = '0; m_ie = '0; m_os = '0; m_ris = '0;
            m_misr = '0; m_pwmr = '0;
            mvalid = 1'b1;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            m_misr[i] = m_ris[i] & m_ie[i];
            m_pwmr[i] = m_en[i] && (m_val[i] < m_cmp[i]);
        end
        wrs = psel && pen && pwr;
        c   = int'(paddr[7:5]);
        r   = int'(paddr[4:2]);
        for (int i = 0; i < NCH; i++) begin
            lw     = wrs && (c == i) && (r == 0);
            tick   = m_en[i] && (m_pc[i] == m_pre[i]) && !lw;
            expire = tick && (m_val[i] == '0);
            if (!m_en[i] || tick) m_pc[i] = '0;
            else m_pc[i] = m_pc[i] + 8'd1;
            if (tick) begin
                if (m_val[i] != '0) m_val[i] = m_val[i] - 16'd1;
                else if (m_os[i]) m_en[i] = 1'b0;
                else m_val[i] = m_load[i];
            end
            if (wrs && (c == i)) begin
                case (r)
                    0: begin
                        m_load[i] = pwdata[W-1:0];
                        m_val[i]  = pwdata[W-1:0];
                        m_pc[i]   = '0;
                    end
                    2: {m_os[i], m_ie[i], m_en[i]} = pwdata[2:0];
                    3: m_pre[i] = pwdata[PW-1:0];
                    4: m_ris[i] = 1'b0;
`ifdef TIMER_PWM_EN
                    7: m_cmp[i] = pwdata[W-1:0];
`endif
                    default: ;
                endcase
            end
            if (expire) m_ris[i] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:2] a);
        int c, r;
        c = int'(a[7:5]);
        r = int'(a[4:2]);
        if (c >= NCH) return 32'd0;
        case (r)
            0: return 32'(m_load[c]);
            1: return 32'(m_val[c]);
            2: return {29'd0, m_os[c], m_ie[c], m_en[c]};
            3: return 32'(m_pre[c]);
            5: return {31'd0, m_ris[c]};
            6: return {31'd0, m_ris[c] & m_ie[c]};
`ifdef TIMER_PWM_EN
            7: return 32'(m_cmp[c]);
`endif
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] m;
        bit          d;
        logic [31:0] dv;
    } rexp_t;

    logic [NCH-1:0] mq [$];
    logic [NCH-1:0] pq [$];
    rexp_t          rq [$];
    bit             d_pend = 1'b0;
    logic [31:0]    d_val  = '0;

    // One clock with the current inputs; expectations are queued first.
    task automatic cyc();
        rexp_t e;
        if (mvalid) begin
            mq.push_back(m_misr);
            pq.push_back(m_pwmr);
            if (psel && pen && !pwr) begin
                e.m  = model_read(paddr);
                e.d  = d_pend;
                e.dv = d_val;
                rq.push_back(e);
            end
        end
        @(posedge clk);
        model_step();
        #2;
    endtask

    logic [NCH-1:0] mon_m, mon_n, mon_p;
    logic           mon_a, mon_an;
    rexp_t          mon_r;

    always @(negedge clk) begin
        if (mq.size() > 0) begin
            mon_m  = mq.pop_front();
            mon_n  = ~mon_m;
            mon_a  = |mon_m;
            mon_an = ~mon_a;
            chk("TIMINT_H", 32'(tim_h), 32'(mon_m));
            chk("TIMINT_L", 32'(tim_l), 32'(mon_n));
            chk("ANY_H", 32'(any_h), 32'(mon_a));
            chk("ANY_L", 32'(any_l), 32'(mon_an));
        end
        if (pq.size() > 0) begin
            mon_p = pq.pop_front();
`ifdef TIMER_PWM_EN
            chk("PWM_H", 32'(pwm_h), 32'(mon_p));
            chk("PWM_L", 32'(pwm_l), 32'(mon_p));
`endif
        end
        if (mvalid && psel && pen && !pwr) begin
            if (rq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL RDQ: read seen, no expectation queued");
            end else begin
                mon_r = rq.pop_front();
                chk($sformatf("RD_H a=%h", paddr), bh.PRDATA, mon_r.m);
                chk($sformatf("RD_L a=%h", paddr), bl.PRDATA, mon_r.m);
                if (mon_r.d)
                    chk($sformatf("RD_DIR a=%h", paddr), bh.PRDATA, mon_r.dv);
            end
        end else if (mvalid && !psel) begin
            chk("RD_IDLE_H", bh.PRDATA, 32'd0);
            chk("RD_IDLE_L", bl.PRDATA, 32'd0);
        end
    end

    task automatic idle(input int n);
        psel = 1'b0; pen = 1'b0; pwr = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [2:0] ch, input logic [2:0] r,
                      input logic [31:0] d);
        psel = 1'b1; pen = 1'b0; pwr = 1'b1;
        paddr = {ch, r}; pwdata = d;
        cyc();
        pen = 1'b1;
        cyc();
        psel = 1'b0; pen = 1'b0;
    endtask

    task automatic rd(input logic [2:0] ch, input logic [2:0] r);
        psel = 1'b1; pen = 1'b0; pwr = 1'b0;
        paddr = {ch, r};
        cyc();
        pen = 1'b1;
        cyc();
        psel = 1'b0; pen = 1'b0;
    endtask

    task automatic rd_exp(input logic [2:0] ch, input logic [2:0] r,
                          input logic [31:0] v);
        d_pend = 1'b1;
        d_val  = v;
        rd(ch, r);
        d_pend = 1'b0;
    endtask

    // Holds the setup phase until the next edge is an expiry of channel ch.
    task automatic wr_on_expiry(input logic [2:0] ch, input logic [2:0] r,
                                input logic [31:0] d);
        int g;
        psel = 1'b1; pen = 1'b0; pwr = 1'b1;
        paddr = {ch, r}; pwdata = d;
        cyc();
        g = 0;
        while (!(m_en[ch] && m_pc[ch] == m_pre[ch] && m_val[ch] == '0)
               && g < 400) begin
            cyc();
            g++;
        end
        if (g >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL EXPIRY_WAIT: ch%0d never reached expiry", ch);
        end
        pen = 1'b1;
        cyc();
        psel = 1'b0; pen = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        idle(n);
        rstn = 1'b1;
    endtask

    initial begin
        int          cnt;
        int          k;
        logic [2:0]  rch, rr;
        logic [31:0] rd_d;

        do_reset(2);
        chk("RST_TIMINT_H", 32'(tim_h), 32'd0);
        chk("RST_ANY_H", 32'(any_h), 32'd0);
        chk("RST_TIMINT_L", 32'(tim_l), 32'hF);
        chk("RST_ANY_L", 32'(any_l), 32'd1);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 8; r++)
                rd_exp(3'(c), 3'(r), 32'd0);

        // ch0 periodic, period 5
        wr(3'd0, 3'd0, 32'd4);
        wr(3'd0, 3'd3, 32'd0);
        wr(3'd0, 3'd2, 32'd3);
        idle(11);
        rd_exp(3'd0, 3'd5, 32'd1);
        wr(3'd0, 3'd4, 32'd0);
        idle(12);
        rd(3'd0, 3'd5);

        // ch2 one-shot, expiry after 12 cycles
        wr(3'd2, 3'd0, 32'd2);
        wr(3'd2, 3'd3, 32'd3);
        wr(3'd2, 3'd2, 32'd7);
        idle(14);
        rd_exp(3'd2, 3'd2, 32'd6);
        rd_exp(3'd2, 3'd1, 32'd0);
        wr(3'd2, 3'd4, 32'd0);
        idle(20);
        rd_exp(3'd2, 3'd5, 32'd0);

        // ch1: INTCLR and LOAD coinciding with expiry
        wr(3'd1, 3'd0, 32'd1);
        wr(3'd1, 3'd3, 32'd9);
        wr(3'd1, 3'd2, 32'd1);
        wr_on_expiry(3'd1, 3'd4, 32'd0);
        rd_exp(3'd1, 3'd5, 32'd1);
        wr(3'd1, 3'd4, 32'd0);
        wr_on_expiry(3'd1, 3'd0, 32'd7);
        rd_exp(3'd1, 3'd1, 32'd7);
        rd_exp(3'd1, 3'd5, 32'd0);

        // Multi-channel: ch0 and ch3 expire, INTEN only on ch3
        do_reset(1);
        wr(3'd0, 3'd0, 32'd3);
        wr(3'd0, 3'd2, 32'd1);
        wr(3'd3, 3'd0, 32'd2);
        wr(3'd3, 3'd2, 32'd3);
        idle(12);
        chk("MULTI_TIMINT_L", 32'(tim_l), 32'h7);
        chk("MULTI_ANY_L", 32'(any_l), 32'd0);
        chk("MULTI_TIMINT_H", 32'(tim_h), 32'h8);
        rd_exp(3'd0, 3'd6, 32'd0);
        rd_exp(3'd0, 3'd5, 32'd1);
        wr(3'd5, 3'd0, 32'h55);
        rd_exp(3'd5, 3'd0, 32'd0);
        rd_exp(3'd5, 3'd2, 32'd0);

`ifdef TIMER_PWM_EN
        do_reset(1);
        wr(3'd0, 3'd0, 32'd9);
        wr(3'd0, 3'd7, 32'd3);
        wr(3'd0, 3'd2, 32'd1);
        idle(15);
        cnt = 0;
        repeat (20) begin cyc(); cnt += int'(pwm_h[0]); end
        chk("PWM_DUTY", 32'(cnt), 32'd6);
        wr(3'd0, 3'd7, 32'd0);
        idle(3);
        cnt = 0;
        repeat (20) begin cyc(); cnt += int'(pwm_h[0]); end
        chk("PWM_CMP0", 32'(cnt), 32'd0);
`endif

        // Randomized traffic against the model
        do_reset(1);
        for (int it = 0; it < 2500; it++) begin
            k   = int'($urandom_range(0, 9));
            rch = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                              : 3'($urandom_range(0, 3));
            rr  = 3'($urandom_range(0, 7));
            if (k <= 2) begin
                idle(int'($urandom_range(1, 4)));
            end else if (k <= 6) begin
                case (rr)
                    3'd0: rd_d = ($urandom_range(0, 7) == 0) ? $urandom
                                 : 32'($urandom_range(0, 9));
                    3'd3: rd_d = 32'($urandom_range(0, 3));
                    3'd7: rd_d = 32'($urandom_range(0, 12));
                    default: rd_d = ($urandom_range(0, 3) == 0) ? $urandom
                                    : 32'($urandom_range(0, 7));
                endcase
                wr(rch, rr, rd_d);
            end else if (k <= 8) begin
                rd(rch, rr);
            end else if ($urandom_range(0, 60) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                idle(1);
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
